// File: rtl/sprite_sequencer_palette_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_sequencer_palette_if
// Description : Bundles the sequencer controls, palette write port, sprite
//               pixel input and the enables/step/rgb outputs of
//               sprite_sequencer_palette.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_sequencer_palette_if #(
    parameter int NUM_SPRITES = 4,
    parameter int PIX_BITS    = 2,
    parameter int STEP_W      = ($clog2(NUM_SPRITES) > 1) ? $clog2(NUM_SPRITES) : 1
);
    logic                   frame_start;
    logic [1:0]             mode;
    logic [NUM_SPRITES-1:0] manual_en;
    logic                   pause;
    logic [PIX_BITS-1:0]    sprite_pixel;
    logic                   pal_we;
    logic [PIX_BITS-1:0]    pal_addr;
    logic [23:0]            pal_data;
    logic [NUM_SPRITES-1:0] enables;
    logic [STEP_W-1:0]      step;
    logic [23:0]            rgb_data;

    // Driver side: timing generator / host that controls the block
    modport master (
        output frame_start, mode, manual_en, pause, sprite_pixel,
        output pal_we, pal_addr, pal_data,
        input  enables, step, rgb_data
    );

    // Block side
    modport slave (
        input  frame_start, mode, manual_en, pause, sprite_pixel,
        input  pal_we, pal_addr, pal_data,
        output enables, step, rgb_data
    );
endinterface
`default_nettype wire

// File: rtl/sprite_sequencer_palette.sv
`default_nettype none
// ============================================================================
// Module      : sprite_sequencer_palette
// Description : Frame-locked sprite-enable sequencer (cumulative, walking-one,
//               blink-all, manual) plus a runtime-writable RGB888 palette that
//               maps the sprite pixel index to rgb_data with one cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_sequencer_palette #(
    parameter int NUM_SPRITES  = 4,
    parameter int PIX_BITS     = 2,
    parameter int DWELL_FRAMES = 32
) (
    input  wire logic                  clk,
    input  wire logic                  resetn,
    sprite_sequencer_palette_if.slave  bus
);
    localparam int STEP_W = ($clog2(NUM_SPRITES) > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CTR_W  = ($clog2(DWELL_FRAMES + 1) > 1) ? $clog2(DWELL_FRAMES + 1) : 1;
    localparam int PAL_N  = 1 << PIX_BITS;

    localparam logic [CTR_W-1:0]  c_ctr_last  = CTR_W'(DWELL_FRAMES - 1);
    localparam logic [STEP_W-1:0] c_step_last = STEP_W'(NUM_SPRITES - 1);

    localparam logic [1:0] c_mode_cumulative = 2'd0;
    localparam logic [1:0] c_mode_walking    = 2'd1;
    localparam logic [1:0] c_mode_blink      = 2'd2;

    logic [CTR_W-1:0]       r_frame_ctr;
    logic [STEP_W-1:0]      r_step;
    logic [NUM_SPRITES-1:0] r_enables;
    logic [23:0]            r_rgb;
    logic [23:0]            r_palette [PAL_N];

    logic                   w_dwell_done;
    logic [STEP_W-1:0]      w_step_new;
    logic [NUM_SPRITES-1:0] w_pattern;

    // Power-on palette contents; entries past the primaries are black
    function automatic logic [23:0] f_default_colour(input int idx);
        case (idx)
            0:       f_default_colour = 24'hFFFFFF;
            1:       f_default_colour = 24'hFF0000;
            2:       f_default_colour = 24'h00FF00;
            3:       f_default_colour = 24'h0000FF;
            default: f_default_colour = 24'h000000;
        endcase
    endfunction

    // Step value that this frame_start would leave behind (pause freezes it)
    always_comb begin
        w_dwell_done = !bus.pause && (r_frame_ctr == c_ctr_last);
        w_step_new   = r_step;
        if (w_dwell_done) begin
            w_step_new = (r_step == c_step_last) ? '0 : r_step + STEP_W'(1);
        end
    end

    // Enable pattern for the current mode evaluated at the upcoming step
    always_comb begin
        w_pattern = '0;
        case (bus.mode)
            c_mode_cumulative: begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    w_pattern[i] = (i <= int'(w_step_new));
                end
            end
            c_mode_walking: begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    w_pattern[i] = (i == int'(w_step_new));
                end
            end
            c_mode_blink: w_pattern = w_step_new[0] ? '0 : '1;
            default:      w_pattern = bus.manual_en;
        endcase
    end

    // Sequencer state only moves on frame_start so enables never tear mid-frame
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_frame_ctr <= '0;
            r_step      <= '0;
            r_enables   <= '0;
        end else if (bus.frame_start) begin
            if (!bus.pause) begin
                r_frame_ctr <= w_dwell_done ? '0 : r_frame_ctr + CTR_W'(1);
            end
            r_step    <= w_step_new;
            r_enables <= w_pattern;
        end
    end

    // Palette register file; a write is visible to reads from the next cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_palette[i] <= f_default_colour(i);
            end
        end else if (bus.pal_we) begin
            r_palette[bus.pal_addr] <= bus.pal_data;
        end
    end

    // Registered pixel lookup, running every cycle including blanking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rgb <= 24'h000000;
        end else begin
            r_rgb <= r_palette[bus.sprite_pixel];
        end
    end

    assign bus.enables  = r_enables;
    assign bus.step     = r_step;
    assign bus.rgb_data = r_rgb;
endmodule
`default_nettype wire

// File: tb/tb_sprite_sequencer_palette.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_sequencer_palette
// Description : Directed bench for sprite_sequencer_palette (4 sprites,
//               2-bit pixels, 2 frames per step) with a cycle-tagged
//               expectation queue drained by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_sequencer_palette;
    localparam int NUM_SPRITES  = 4;
    localparam int PIX_BITS     = 2;
    localparam int DWELL_FRAMES = 2;

    localparam int c_fld_en   = 0;
    localparam int c_fld_step = 1;
    localparam int c_fld_rgb  = 2;

    typedef struct {
        int          cyc;
        int          fld;
        logic [23:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   checks;
    int   errors;
    bit   stim_done;
    exp_t sb_q[$];

    sprite_sequencer_palette_if #(.NUM_SPRITES(NUM_SPRITES), .PIX_BITS(PIX_BITS)) bus ();

    sprite_sequencer_palette #(
        .NUM_SPRITES (NUM_SPRITES),
        .PIX_BITS    (PIX_BITS),
        .DWELL_FRAMES(DWELL_FRAMES)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expectations can be tagged with a target cycle
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a value to be visible after the next rising edge
    task automatic exp_next(input int fld, input logic [23:0] val, input string name);
        exp_t e;
        e.cyc = cyc + 1; e.fld = fld; e.val = val; e.name = name;
        sb_q.push_back(e);
    endtask

    // Expect a value that is already registered now
    task automatic exp_now(input int fld, input logic [23:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.fld = fld; e.val = val; e.name = name;
        sb_q.push_back(e);
    endtask

    // One frame_start pulse, then one idle cycle proving enables stay put
    task automatic pulse(input logic [3:0] en, input int st, input string name);
        bus.frame_start = 1'b1;
        exp_next(c_fld_en, 24'(en), {name, "_en"});
        exp_next(c_fld_step, 24'(st), {name, "_step"});
        tick();
        bus.frame_start = 1'b0;
        exp_next(c_fld_en, 24'(en), {name, "_hold"});
        tick();
    endtask

    // Monitor: sample on the falling edge and retire every due expectation
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            logic [23:0] act;
            e = sb_q.pop_front();
            case (e.fld)
                c_fld_en:   act = 24'(bus.enables);
                c_fld_step: act = 24'(bus.step);
                default:    act = bus.rgb_data;
            endcase
            checks = checks + 1;
            if (act !== e.val) begin
                errors = errors + 1;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        stim_done = 1'b0;
        resetn = 1'b0;
        bus.frame_start = 1'b0;
        bus.mode = 2'd0;
        bus.manual_en = '0;
        bus.pause = 1'b0;
        bus.sprite_pixel = 2'd1;
        bus.pal_we = 1'b0;
        bus.pal_addr = '0;
        bus.pal_data = '0;

        // Reset defaults
        repeat (3) tick();
        exp_now(c_fld_en, 24'h0, "rst_en");
        exp_now(c_fld_step, 24'h0, "rst_step");
        exp_now(c_fld_rgb, 24'h000000, "rst_rgb");
        tick();
        resetn = 1'b1;
        exp_next(c_fld_rgb, 24'hFF0000, "pal1_default");
        tick();
        bus.sprite_pixel = 2'd0;
        exp_next(c_fld_rgb, 24'hFFFFFF, "pal0_default");
        tick();

        // Cumulative mode, two frames per step
        pulse(4'b0001, 0, "cum_p1");
        pulse(4'b0011, 1, "cum_p2");
        pulse(4'b0011, 1, "cum_p3");
        pulse(4'b0111, 2, "cum_p4");
        pulse(4'b0111, 2, "cum_p5");
        pulse(4'b1111, 3, "cum_p6");
        pulse(4'b1111, 3, "cum_p7");
        pulse(4'b0001, 0, "cum_p8_wrap");
        pulse(4'b0001, 0, "cum_p9");
        pulse(4'b0011, 1, "cum_p10");
        pulse(4'b0011, 1, "cum_p11");
        pulse(4'b0111, 2, "cum_p12");

        // Mid-frame mode switch must not disturb enables
        bus.mode = 2'd1;
        exp_next(c_fld_en, 24'h7, "mode_midframe");
        tick();
        bus.pause = 1'b1;
        pulse(4'b0100, 2, "walk_step2");
        bus.mode = 2'd2;
        pulse(4'b1111, 2, "blink_step2");
        bus.pause = 1'b0;
        pulse(4'b1111, 2, "blink_step2b");
        pulse(4'b0000, 3, "blink_step3");
        bus.mode = 2'd3;
        bus.manual_en = 4'b1010;
        pulse(4'b1010, 3, "manual_1010");

        // Pause across five frames: step/counter frozen, patterns recomputed
        bus.pause = 1'b1;
        bus.mode = 2'd0; pulse(4'b1111, 3, "pause_cum");
        bus.mode = 2'd1; pulse(4'b1000, 3, "pause_walk");
        bus.mode = 2'd2; pulse(4'b0000, 3, "pause_blink");
        bus.mode = 2'd3; bus.manual_en = 4'b0101; pulse(4'b0101, 3, "pause_manual");
        bus.mode = 2'd0; pulse(4'b1111, 3, "pause_cum2");
        bus.pause = 1'b0;
        pulse(4'b0001, 0, "resume_wrap");

        // Palette write collides with a read of the same entry
        bus.sprite_pixel = 2'd2;
        exp_next(c_fld_rgb, 24'h00FF00, "pal2_default");
        tick();
        bus.pal_we = 1'b1; bus.pal_addr = 2'd2; bus.pal_data = 24'h123456;
        exp_next(c_fld_rgb, 24'h00FF00, "pal_collide_old");
        tick();
        bus.pal_we = 1'b0;
        exp_next(c_fld_rgb, 24'h123456, "pal_collide_new");
        tick();
        resetn = 1'b0;
        exp_next(c_fld_rgb, 24'h000000, "pal_rst_rgb");
        tick();
        resetn = 1'b1;
        exp_next(c_fld_rgb, 24'h00FF00, "pal2_restored");
        tick();

        // Reset at step 3 coinciding with frame_start and a palette write
        pulse(4'b0001, 0, "re_p1");
        pulse(4'b0011, 1, "re_p2");
        pulse(4'b0011, 1, "re_p3");
        pulse(4'b0111, 2, "re_p4");
        pulse(4'b0111, 2, "re_p5");
        pulse(4'b1111, 3, "re_p6");
        resetn = 1'b0;
        bus.frame_start = 1'b1;
        bus.pal_we = 1'b1; bus.pal_addr = 2'd2; bus.pal_data = 24'hABCDEF;
        exp_next(c_fld_en, 24'h0, "midrst_en");
        exp_next(c_fld_step, 24'h0, "midrst_step");
        exp_next(c_fld_rgb, 24'h000000, "midrst_rgb");
        tick();
        resetn = 1'b1;
        bus.frame_start = 1'b0;
        bus.pal_we = 1'b0;
        exp_next(c_fld_rgb, 24'h00FF00, "midrst_write_dropped");
        tick();
        bus.sprite_pixel = 2'd3;
        exp_next(c_fld_rgb, 24'h0000FF, "pal3_default");
        tick();
        pulse(4'b0001, 0, "postrst_p1");
        pulse(4'b0011, 1, "postrst_p2");

        repeat (3) tick();
        stim_done = 1'b1;

        // Settled state after the final frame pulses
        checks = checks + 1;
        if (bus.enables !== 4'b0011) begin
            errors = errors + 1;
            $display("FAIL final_en: got %b expected 0011", bus.enables);
        end
        checks = checks + 1;
        if (bus.step !== 2'd1) begin
            errors = errors + 1;
            $display("FAIL final_step: got %0d expected 1", bus.step);
        end
        checks = checks + 1;
        if (bus.rgb_data !== 24'h0000FF) begin
            errors = errors + 1;
            $display("FAIL final_rgb: got %h expected 0000ff", bus.rgb_data);
        end

        // Anything still queued was never observed
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: got no sample expected %h", e.name, e.val);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sprite_sequencer_palette.md
Name: sprite_sequencer_palette

Overview:
Parametrised successor to the fixed 4-sprite enable cycler and hard-wired 2-bit palette in the sprite test top. Steps a sprite-enable pattern through one of four modes, with updates locked to frame boundaries so no frame ever tears. Maps the sprite engine's pixel index to 24-bit RGB through a runtime-writable palette register file. Sits between the sprites block (enables, pixel) and lcd_ctrl (rgb_data).

Parameters:
NUM_SPRITES, 4, number of sprite enable bits (>=2)
PIX_BITS, 2, sprite pixel index width; palette has 2^PIX_BITS entries (<=4)
DWELL_FRAMES, 32, frames per sequencer step (>=1)

Ports:
clk  in  1  pixel clock
resetn  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each frame (from lcd_ctrl timing)
mode  in  2  0 cumulative, 1 walking-one, 2 blink-all, 3 manual
manual_en  in  NUM_SPRITES  enable pattern used in mode 3
pause  in  1  freezes step/frame counters
sprite_pixel  in  PIX_BITS  palette index from sprites block
pal_we  in  1  palette write strobe
pal_addr  in  PIX_BITS  palette write address
pal_data  in  24  palette write data, RGB888
enables  out  NUM_SPRITES  registered sprite enables to sprites block
step  out  max(1,clog2(NUM_SPRITES))  current sequencer step
rgb_data  out  24  registered palette output

Behaviour:
- All state updates on posedge clk; resetn sampled only on clk edge.
- Reset (resetn=0), any time incl. mid-frame: step=0, frame_ctr=0, enables=0, rgb_data=24'h000000; palette[0]=FFFFFF, [1]=FF0000, [2]=00FF00, [3]=0000FF, [4..]=000000 (entries beyond 2^PIX_BITS not present).
- frame_ctr width clog2(DWELL_FRAMES+1); counts frame_start pulses only.
- On frame_start=1 and pause=0: if frame_ctr==DWELL_FRAMES-1 -> frame_ctr=0, step_new = (step==NUM_SPRITES-1) ? 0 : step+1; else frame_ctr+1, step_new=step.
- On frame_start=1 and pause=1: frame_ctr and step hold; step_new=step.
- On frame_start=1 (either pause value): enables <= pattern(mode, step_new), same edge as step update. enables never changes on any other cycle.
- Patterns: mode0 bits [step_new:0] set, rest 0. Mode1 only bit step_new. Mode2 all ones if step_new even, all zeros if odd. Mode3 manual_en, sampled at that edge.
- Step advances in all modes, incl. manual. Mode change does not reset step; it takes effect at next frame_start.
- DWELL_FRAMES=1: step advances every frame_start.
- Step wraps NUM_SPRITES-1 -> 0. No other wrap states.
- Pixel path: rgb_data <= palette[sprite_pixel] every cycle (incl. blanking). Latency 1 cycle, independent of sequencer.
- Palette write: pal_we=1 writes pal_data to palette[pal_addr] at edge. A same-cycle read of the same address returns the old value. The new value appears on rgb_data one cycle later if the index is still held.
- resetn=0 overrides pal_we and frame_start in the same cycle.
- No handshake on frame_start; back-to-back pulses are each counted.

Test Plan:
- Reset defaults: hold resetn=0 3 cycles, sprite_pixel=1 -> enables=0, step=0, rgb_data=000000; release, next cycle rgb_data=FF0000. sprite_pixel=0 -> FFFFFF one cycle later.
- Cumulative sequence: NUM_SPRITES=4, DWELL_FRAMES=2, mode=0, 10 frame_start pulses. Pulse1 -> enables=0001. Pulse2 -> 0011 (step1). Pulse4 -> 0111. Pulse6 -> 1111. Pulse8 -> 0001 (wrap to step0).
- Modes: at step 2, switch mode 0->1 mid-frame -> enables unchanged until next frame_start, then 0100. Mode2 at step 2 -> 1111; at step 3 -> 0000. Mode3 with manual_en=1010 -> 1010 at next frame_start.
- Pause: pause=1 across 5 frame_start pulses -> step and frame_ctr constant, enables recomputed (mode switch still applied). Release -> counting resumes from held frame_ctr.
- Palette write collision: sprite_pixel=2 held, pal_we=1, pal_addr=2, pal_data=123456 for one cycle -> rgb_data 00FF00 after that edge, 123456 the following cycle. Then resetn pulse -> palette[2] back to 00FF00.
- Reset mid-operation: assert resetn=0 at step 3 in the same cycle as frame_start and pal_we -> step=0, enables=0, palette restored to defaults, write discarded.
